lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_fault_chk.sv | 27 ++
 rtl/lsu.sv | 118 +++++++++++
 tb/tb_lsu.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and defaults for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic {
        SG_SIGNED   = 1'b0,
        SG_UNSIGNED = 1'b1
    } sign_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_e;

    localparam logic [31:0] MMIO_BASE_DEF = 32'h1100_0000;

endpackage

// File: rtl/lsu_fault_chk.sv
// lsu_fault_chk: combinational alignment/range fault and IO-region classification
module lsu_fault_chk
    import lsu_pkg::*;
#(
    parameter int          MEM_WIDTH = 15,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    output logic        fault,
    output logic        is_io
);

    logic w_in_mem;
    logic w_misalign;

    // Region decode: data memory sits at the bottom, MMIO from MMIO_BASE upward, the gap faults
    always_comb begin
        w_in_mem   = (addr >> MEM_WIDTH) == 32'd0;
        is_io      = addr >= MMIO_BASE;
        w_misalign = (size == 2'b11) ||
                     (size == SZ_HALF && addr[0]) ||
                     (size == SZ_WORD && addr[1:0] != 2'b00);
        fault      = w_misalign || (!w_in_mem && !is_io) || (is_io && size != SZ_WORD);
    end

endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit routing CPU requests to data memory or MMIO
module lsu
    import lsu_pkg::*;
#(
    parameter int          MEM_WIDTH = 15,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic        mem_sign,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        io_rd,
    output logic        io_wr,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata
);

    state_e      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [1:0]  r_size;
    logic        r_sign;
    logic        r_we;
    logic        r_io;
    logic        r_err;
    logic        w_fault;
    logic        w_io;

    lsu_fault_chk #(
        .MEM_WIDTH (MEM_WIDTH),
        .MMIO_BASE (MMIO_BASE)
    ) u_fault_chk (
        .addr  (req_addr),
        .size  (req_size),
        .fault (w_fault),
        .is_io (w_io)
    );

    // Request FSM: latch on accept, faults skip straight to RESP, memory loads take an extra capture cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_size  <= '0;
            r_sign  <= 1'b0;
            r_we    <= 1'b0;
            r_io    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_addr  <= req_addr;
                    r_wdata <= req_wdata;
                    r_size  <= req_size;
                    r_sign  <= req_sign;
                    r_we    <= req_we;
                    r_io    <= w_io;
                    r_err   <= w_fault;
                    r_rdata <= '0;
                    r_state <= w_fault ? S_RESP : S_ISSUE;
                end
                S_ISSUE: begin
                    if (r_io) begin
                        r_rdata <= r_we ? 32'd0 : io_rdata;
                        r_state <= S_RESP;
                    end else begin
                        r_err   <= mem_err;
                        r_state <= r_we ? S_RESP : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_rdata <= r_err ? 32'd0 : mem_rdata;
                    r_state <= S_RESP;
                end
                S_RESP: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode from state so each fires for exactly the one ISSUE cycle
    always_comb begin
        req_ready  = r_state == S_IDLE;
        resp_valid = r_state == S_RESP;
        resp_err   = resp_valid && r_err;
        resp_rdata = r_rdata;
        mem_rd     = r_state == S_ISSUE && !r_io && !r_we;
        mem_wr     = r_state == S_ISSUE && !r_io && r_we;
        io_rd      = r_state == S_ISSUE && r_io && !r_we;
        io_wr      = r_state == S_ISSUE && r_io && r_we;
        mem_addr   = r_addr;
        mem_wdata  = r_wdata;
        mem_size   = r_size;
        mem_sign   = r_sign;
        io_addr    = r_addr;
        io_wdata   = r_wdata;
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for the load/store unit
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_sign;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        io_rd;
    logic        io_wr;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .req_sign   (req_sign),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_size   (mem_size),
        .mem_sign   (mem_sign),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err),
        .io_rd      (io_rd),
        .io_wr      (io_wr),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; on return we are #1 into the first cycle after acceptance
    task automatic go(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input logic sign);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        req_sign  = sign;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = '0; req_sign = 1'b0; mem_rdata = '0; mem_err = 1'b0; io_rdata = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_strobes", {26'd0, resp_valid, resp_err, mem_rd, mem_wr, io_rd, io_wr}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_io_wdata", io_wdata, 32'd0);
        chk("rst_size_sign", {29'd0, mem_size, mem_sign}, 32'd0);

        // lw 0x100 from memory
        mem_rdata = 32'hDEAD_BEEF;
        go(1'b0, 32'h0000_0100, 32'd0, 2'b10, 1'b0);
        chk("lw_c1_mem_rd", {31'd0, mem_rd}, 32'd1);
        chk("lw_c1_ready", {31'd0, req_ready}, 32'd0);
        chk("lw_c1_addr", mem_addr, 32'h0000_0100);
        chk("lw_c1_size", {30'd0, mem_size}, 32'd2);
        step();
        chk("lw_c2_quiet", {30'd0, mem_rd, resp_valid}, 32'd0);
        step();
        chk("lw_c3_valid", {31'd0, resp_valid}, 32'd1);
        chk("lw_c3_rdata", resp_rdata, 32'hDEAD_BEEF);
        chk("lw_c3_err", {31'd0, resp_err}, 32'd0);
        chk("lw_c3_ready", {31'd0, req_ready}, 32'd0);
        step();
        chk("lw_c4_idle", {30'd0, req_ready, resp_valid}, 32'd2);

        // sh 0x202
        go(1'b1, 32'h0000_0202, 32'h0000_1234, 2'b01, 1'b0);
        chk("sh_c1_strobes", {28'd0, mem_rd, mem_wr, io_rd, io_wr}, 32'h4);
        chk("sh_c1_size", {30'd0, mem_size}, 32'd1);
        chk("sh_c1_wdata", mem_wdata, 32'h0000_1234);
        step();
        chk("sh_c2_resp", {29'd0, resp_valid, resp_err, mem_wr}, 32'h4);
        step();

        // misaligned lw 0x102
        go(1'b0, 32'h0000_0102, 32'd0, 2'b10, 1'b0);
        chk("mis_c1_resp", {30'd0, resp_valid, resp_err}, 32'h3);
        chk("mis_c1_strobes", {28'd0, mem_rd, mem_wr, io_rd, io_wr}, 32'd0);
        chk("mis_c1_rdata", resp_rdata, 32'd0);
        step();

        // sw to MMIO
        go(1'b1, 32'h1100_0020, 32'h0000_00A5, 2'b10, 1'b0);
        chk("iow_c1_strobes", {28'd0, mem_rd, mem_wr, io_rd, io_wr}, 32'h1);
        chk("iow_c1_addr", io_addr, 32'h1100_0020);
        chk("iow_c1_wdata", io_wdata, 32'h0000_00A5);
        step();
        chk("iow_c2_resp", {29'd0, resp_valid, resp_err, io_wr}, 32'h4);
        step();

        // lb to MMIO faults
        go(1'b0, 32'h1100_0000, 32'd0, 2'b00, 1'b0);
        chk("iolb_c1_resp", {30'd0, resp_valid, resp_err}, 32'h3);
        step();

        // lh into the gap above data memory faults
        go(1'b0, 32'h0000_8000, 32'd0, 2'b01, 1'b0);
        chk("gap_c1_resp", {30'd0, resp_valid, resp_err}, 32'h3);
        step();

        // size 11 faults even when aligned in memory
        go(1'b0, 32'h0000_0000, 32'd0, 2'b11, 1'b0);
        chk("sz3_c1_resp", {30'd0, resp_valid, resp_err}, 32'h3);
        step();

        // lw from MMIO returns io_rdata raw
        io_rdata = 32'hCAFE_F00D;
        go(1'b0, 32'h1100_0004, 32'd0, 2'b10, 1'b0);
        chk("ior_c1_strobes", {28'd0, mem_rd, mem_wr, io_rd, io_wr}, 32'h2);
        step();
        io_rdata = 32'd0;
        chk("ior_c2_resp", {30'd0, resp_valid, resp_err}, 32'h2);
        chk("ior_c2_rdata", resp_rdata, 32'hCAFE_F00D);
        step();

        // lbu passes sign/size through and memory data unmodified
        mem_rdata = 32'h0000_00FF;
        go(1'b0, 32'h0000_0101, 32'd0, 2'b00, 1'b1);
        chk("lbu_c1_meta", {28'd0, mem_rd, mem_sign, mem_size}, 32'hC);
        step();
        step();
        chk("lbu_c3_rdata", resp_rdata, 32'h0000_00FF);
        step();

        // memory error during ISSUE
        mem_rdata = 32'h1234_5678;
        go(1'b0, 32'h0000_0200, 32'd0, 2'b10, 1'b0);
        mem_err = 1'b1;
        step();
        mem_err = 1'b0;
        step();
        chk("merr_c3_resp", {30'd0, resp_valid, resp_err}, 32'h3);
        chk("merr_c3_rdata", resp_rdata, 32'd0);
        step();

        // reset during CAPTURE discards the load
        mem_rdata = 32'h1111_2222;
        go(1'b0, 32'h0000_0104, 32'd0, 2'b10, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstcap_ready", {30'd0, req_ready, resp_valid}, 32'h2);
        step();
        chk("rstcap_no_resp", {31'd0, resp_valid}, 32'd0);
        mem_rdata = 32'h0BAD_F00D;
        go(1'b0, 32'h0000_0108, 32'd0, 2'b10, 1'b0);
        chk("after_c1_mem_rd", {31'd0, mem_rd}, 32'd1);
        step();
        step();
        chk("after_c3_resp", {30'd0, resp_valid, resp_err}, 32'h2);
        chk("after_c3_rdata", resp_rdata, 32'h0BAD_F00D);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
